a2d_rr_intf: RTL and testbench

Round-robin front end for the ADC128S 8-channel 12-bit SPI A/D converter. Each single-cycle nxt pulse triggers one conversion of the next channel in the sequence lft_ld -> rght_ld -> steer_pot -> batt -> lft_ld. A conversion is two back-to-back 16-bit SPI transactions. The result is held in the matching output register. The block sits between the Segway sensor inputs and the balance/steer/battery logic.

---
 rtl/a2d_pkg.sv | 29 ++
 rtl/spi_mnrch.sv | 101 ++++++++++
 rtl/a2d_rr_intf.sv | 150 +++++++++++++++
 tb/tb_a2d_rr_intf.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared types and helpers for the ADC128S round-robin front end:
// controller/SPI state encodings, default channel map and command word builder.
package a2d_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CNV  = 2'd1,
      GAP  = 2'd2,
      READ = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      SPI_IDLE = 2'd0,
      FRONT    = 2'd1,
      XFER     = 2'd2,
      BACK     = 2'd3
   } spi_state_t;

   localparam logic [2:0] CH_LFT_DEF   = 3'd0;
   localparam logic [2:0] CH_RGHT_DEF  = 3'd4;
   localparam logic [2:0] CH_STEER_DEF = 3'd5;
   localparam logic [2:0] CH_BATT_DEF  = 3'd6;

   // ADC128S control word: channel address lands in bits [13:11]
   function automatic logic [15:0] cmd_word(input logic [2:0] ch);
      return {2'b00, ch, 11'h000};
   endfunction

endpackage

// File: rtl/spi_mnrch.sv
// SPI master for the ADC128S: one 16-bit MSB-first frame per wrt pulse,
// SCLK idling high, with half-period front and back porches around the frame.
module spi_mnrch
   import a2d_pkg::*;
#(
   parameter int SCLK_DIV_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wrt,
   input  logic [15:0] wt_data,
   output logic [15:0] rd_data,
   output logic        done,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   input  logic        MISO
);

   localparam logic [SCLK_DIV_W-1:0] HALF_M1 = SCLK_DIV_W'((1 << (SCLK_DIV_W - 1)) - 1);
   localparam logic [SCLK_DIV_W-1:0] FULL_M1 = {SCLK_DIV_W{1'b1}};

   spi_state_t            st_r;
   logic [SCLK_DIV_W-1:0] cnt_r;
   logic [3:0]            bit_cnt_r;
   logic [15:0]           shft_r;
   logic                  miso_r;
   logic                  ss_n_r;
   logic                  sclk_r;
   logic                  done_r;

   // Porch/transfer sequencer: cnt_r == HALF_M1 marks a falling SCLK, FULL_M1 a rising SCLK.
   // MISO is captured on the rise and shifted in on the following fall (or at the back porch)
   // so MOSI only ever moves while SCLK falls.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_r      <= SPI_IDLE;
         cnt_r     <= '0;
         bit_cnt_r <= 4'd0;
         shft_r    <= 16'h0000;
         miso_r    <= 1'b0;
         ss_n_r    <= 1'b1;
         sclk_r    <= 1'b1;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (st_r)
            SPI_IDLE: begin
               if (wrt) begin
                  ss_n_r    <= 1'b0;
                  sclk_r    <= 1'b1;
                  cnt_r     <= '0;
                  bit_cnt_r <= 4'd0;
                  shft_r    <= wt_data;
                  st_r      <= FRONT;
               end
            end
            FRONT: begin
               cnt_r <= cnt_r + 1'b1;
               if (cnt_r == HALF_M1) begin
                  sclk_r <= 1'b0;
                  st_r   <= XFER;
               end
            end
            XFER: begin
               cnt_r <= cnt_r + 1'b1;
               if (cnt_r == HALF_M1) begin
                  sclk_r <= 1'b0;
                  shft_r <= {shft_r[14:0], miso_r};
               end else if (cnt_r == FULL_M1) begin
                  sclk_r    <= 1'b1;
                  miso_r    <= MISO;
                  bit_cnt_r <= bit_cnt_r + 4'd1;
                  if (bit_cnt_r == 4'd15) begin
                     st_r <= BACK;
                  end
               end
            end
            BACK: begin
               cnt_r <= cnt_r + 1'b1;
               if (cnt_r == HALF_M1) begin
                  ss_n_r <= 1'b1;
                  shft_r <= {shft_r[14:0], miso_r};
                  done_r <= 1'b1;
                  st_r   <= SPI_IDLE;
               end
            end
            default: begin
               st_r <= SPI_IDLE;
            end
         endcase
      end
   end

   assign rd_data = shft_r;
   assign done    = done_r;
   assign SS_n    = ss_n_r;
   assign SCLK    = sclk_r;
   assign MOSI    = shft_r[15];

endmodule

// File: rtl/a2d_rr_intf.sv
// Round-robin ADC128S conversion sequencer: lft_ld -> rght_ld -> steer_pot -> batt.
// Optional A2D_CNV_CMPLT_EN adds a one-clk cnv_cmplt pulse per output update.
module a2d_rr_intf
   import a2d_pkg::*;
#(
   parameter int         SCLK_DIV_W = 4,
   parameter logic [2:0] CH_LFT     = CH_LFT_DEF,
   parameter logic [2:0] CH_RGHT    = CH_RGHT_DEF,
   parameter logic [2:0] CH_STEER   = CH_STEER_DEF,
   parameter logic [2:0] CH_BATT    = CH_BATT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        nxt,
   output logic [11:0] lft_ld,
   output logic [11:0] rght_ld,
   output logic [11:0] steer_pot,
   output logic [11:0] batt,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   input  logic        MISO
`ifdef A2D_CNV_CMPLT_EN
   ,
   output logic        cnv_cmplt
`endif
);

   state_t      state_r;
   logic [1:0]  idx_r;
   logic [11:0] lft_ld_r;
   logic [11:0] rght_ld_r;
   logic [11:0] steer_pot_r;
   logic [11:0] batt_r;
   logic [2:0]  ch_s;
   logic [15:0] cmd_s;
   logic        wrt_s;
   logic [15:0] rx_s;
   logic        done_s;
   logic        unused_rx_s;
`ifdef A2D_CNV_CMPLT_EN
   logic        cnv_cmplt_r;
`endif

   // Channel addressed by the current round-robin slot
   always_comb begin
      ch_s = CH_LFT;
      case (idx_r)
         2'd0:    ch_s = CH_LFT;
         2'd1:    ch_s = CH_RGHT;
         2'd2:    ch_s = CH_STEER;
         2'd3:    ch_s = CH_BATT;
         default: ch_s = CH_LFT;
      endcase
   end

   assign cmd_s = cmd_word(ch_s);

   // Kick the SPI engine straight from state so the GAP state lasts a single clk
   always_comb begin
      wrt_s = 1'b0;
      if (state_r == IDLE) begin
         wrt_s = nxt;
      end else if (state_r == GAP) begin
         wrt_s = 1'b1;
      end else begin
         wrt_s = 1'b0;
      end
   end

   spi_mnrch #(
      .SCLK_DIV_W (SCLK_DIV_W)
   ) u_spi (
      .clk     (clk),
      .rst     (rst),
      .wrt     (wrt_s),
      .wt_data (cmd_s),
      .rd_data (rx_s),
      .done    (done_s),
      .SS_n    (SS_n),
      .SCLK    (SCLK),
      .MOSI    (MOSI),
      .MISO    (MISO)
   );

   // The ADC's leading status nibble carries no data
   assign unused_rx_s = ^rx_s[15:12];

   // Conversion sequencer and result registers; only READ completion touches the outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         idx_r       <= 2'd0;
         lft_ld_r    <= 12'h000;
         rght_ld_r   <= 12'h000;
         steer_pot_r <= 12'h000;
         batt_r      <= 12'h000;
`ifdef A2D_CNV_CMPLT_EN
         cnv_cmplt_r <= 1'b0;
`endif
      end else begin
`ifdef A2D_CNV_CMPLT_EN
         cnv_cmplt_r <= 1'b0;
`endif
         case (state_r)
            IDLE: begin
               if (nxt) begin
                  state_r <= CNV;
               end
            end
            CNV: begin
               if (done_s) begin
                  state_r <= GAP;
               end
            end
            GAP: begin
               state_r <= READ;
            end
            READ: begin
               if (done_s) begin
                  case (idx_r)
                     2'd0:    lft_ld_r    <= rx_s[11:0];
                     2'd1:    rght_ld_r   <= rx_s[11:0];
                     2'd2:    steer_pot_r <= rx_s[11:0];
                     2'd3:    batt_r      <= rx_s[11:0];
                     default: lft_ld_r    <= rx_s[11:0];
                  endcase
                  idx_r   <= idx_r + 2'd1;
                  state_r <= IDLE;
`ifdef A2D_CNV_CMPLT_EN
                  cnv_cmplt_r <= 1'b1;
`endif
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign lft_ld    = lft_ld_r;
   assign rght_ld   = rght_ld_r;
   assign steer_pot = steer_pot_r;
   assign batt      = batt_r;
`ifdef A2D_CNV_CMPLT_EN
   assign cnv_cmplt = cnv_cmplt_r;
`endif

endmodule

// File: tb/tb_a2d_rr_intf.sv
// Self-checking bench for a2d_rr_intf with a behavioural ADC128S slave model.
module tb_a2d_rr_intf;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        nxt = 1'b0;
   logic [11:0] lft_ld, rght_ld, steer_pot, batt;
   logic        SS_n, SCLK, MOSI, MISO;
`ifdef A2D_CNV_CMPLT_EN
   logic        cnv_cmplt;
`endif

   a2d_rr_intf dut (
      .clk       (clk),
      .rst       (rst),
      .nxt       (nxt),
      .lft_ld    (lft_ld),
      .rght_ld   (rght_ld),
      .steer_pot (steer_pot),
      .batt      (batt),
      .SS_n      (SS_n),
      .SCLK      (SCLK),
      .MOSI      (MOSI),
      .MISO      (MISO)
`ifdef A2D_CNV_CMPLT_EN
      ,
      .cnv_cmplt (cnv_cmplt)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // ADC128S model state
   logic [15:0] adc_val [8];
   logic [15:0] miso_word = 16'h0000;
   logic [15:0] mosi_sh;
   logic [2:0]  prev_ch = 3'd0;
   logic [15:0] frames [$];
   int          frame_bits [$];
   int          ss_fall_cnt = 0;

   assign MISO = miso_word[15];

   // Reference model: slot -> command word, expected outputs
   logic [15:0] cmd_tab [4] = '{16'h0000, 16'h2000, 16'h2800, 16'h3000};
   int          ch_tab  [4] = '{0, 4, 5, 6};
   logic [11:0] exp_o   [4];
   int          idx_m = 0;

   initial begin : adc_model
      int rises;
      forever begin
         @(negedge SS_n);
         ss_fall_cnt++;
         rises     = 0;
         mosi_sh   = 16'h0000;
         miso_word = adc_val[prev_ch];
         while (!SS_n) begin
            @(posedge SCLK or posedge SS_n);
            if (!SS_n) begin
               mosi_sh = {mosi_sh[14:0], MOSI};
               rises++;
               @(negedge SCLK or posedge SS_n);
               if (!SS_n) miso_word = {miso_word[14:0], 1'b0};
            end
         end
         frames.push_back(mosi_sh);
         frame_bits.push_back(rises);
         if (rises == 16) prev_ch = mosi_sh[13:11];
      end
   end

`ifdef A2D_CNV_CMPLT_EN
   int          cmplt_pulses = 0;
   int          cmplt_wide   = 0;
   int          cmplt_miss   = 0;
   logic        prev_c = 1'b0;
   logic [47:0] prev_all = 48'h0;
   always @(negedge clk) begin
      if (cnv_cmplt === 1'b1 && prev_c !== 1'b1) cmplt_pulses++;
      if (cnv_cmplt === 1'b1 && prev_c === 1'b1) cmplt_wide++;
      if (!rst && ({lft_ld, rght_ld, steer_pot, batt} != prev_all) && cnv_cmplt !== 1'b1) cmplt_miss++;
      prev_c   = cnv_cmplt;
      prev_all = {lft_ld, rght_ld, steer_pot, batt};
   end
`endif

   function automatic logic [11:0] dut_out(input int k);
      case (k)
         0:       return lft_ld;
         1:       return rght_ld;
         2:       return steer_pot;
         default: return batt;
      endcase
   endfunction

   task automatic model_conv();
      exp_o[idx_m] = adc_val[ch_tab[idx_m]][11:0];
      idx_m = (idx_m + 1) % 4;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) exp_o[k] = 12'h000;
      idx_m = 0;
   endtask

   // One nxt pulse (optionally re-pulsed 5 clk later); waits, bounded, for both frames
   task automatic do_conv(input bit repulse, output bit ok, output int lat);
      int base;
      base = frames.size();
      @(negedge clk) nxt = 1'b1;
      @(negedge clk) nxt = 1'b0;
      lat = 1;
      if (repulse) begin
         repeat (4) @(negedge clk);
         nxt = 1'b1;
         @(negedge clk) nxt = 1'b0;
         lat += 5;
      end
      while (frames.size() < base + 2 && lat < 1000) begin
         @(negedge clk);
         lat++;
      end
      ok = (frames.size() >= base + 2);
      repeat (2) @(negedge clk);
      lat += 2;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 8; k++) adc_val[k] = 16'($urandom);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (dut_out(k) !== 12'h000) begin
            n_err++;
            $display("FAIL reset_out%0d actual=%h required=000", k, dut_out(k));
         end
      end
      n_cmp++;
      if (SS_n !== 1'b1 || SCLK !== 1'b1 || MOSI !== 1'b0) begin
         n_err++;
         $display("FAIL reset_pins actual SS_n=%b SCLK=%b MOSI=%b required 1/1/0", SS_n, SCLK, MOSI);
      end
`ifdef A2D_CNV_CMPLT_EN
      n_cmp++;
      if (cnv_cmplt !== 1'b0) begin
         n_err++;
         $display("FAIL reset_cmplt actual=%b required=0", cnv_cmplt);
      end
`endif
      repeat (100) @(negedge clk);
      n_cmp++;
      if (ss_fall_cnt !== 0 || SS_n !== 1'b1) begin
         n_err++;
         $display("FAIL idle_quiet actual falls=%0d SS_n=%b required 0/1", ss_fall_cnt, SS_n);
      end
   endtask

   task automatic test_single();
      bit ok; int lat; int base; int falls;
      adc_val[0] = 16'hFABC;
      base  = frames.size();
      falls = ss_fall_cnt;
      do_conv(1'b0, ok, lat);
      model_conv();
      n_cmp++;
      if (!ok || lat >= 1000) begin
         n_err++;
         $display("FAIL single_latency actual=%0d ok=%0b required <1000", lat, ok);
      end
      n_cmp++;
      if (ss_fall_cnt - falls !== 2) begin
         n_err++;
         $display("FAIL single_windows actual=%0d required=2", ss_fall_cnt - falls);
      end
      if (ok) begin
         n_cmp++;
         if (frames[base] !== 16'h0000 || frames[base+1] !== 16'h0000) begin
            n_err++;
            $display("FAIL single_cmd actual=%h,%h required=0000,0000", frames[base], frames[base+1]);
         end
      end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (dut_out(k) !== exp_o[k]) begin
            n_err++;
            $display("FAIL single_out%0d actual=%h required=%h", k, dut_out(k), exp_o[k]);
         end
      end
   endtask

   task automatic test_ignore_nxt();
      bit ok; int lat; int base;
      base = frames.size();
      do_conv(1'b1, ok, lat);
      model_conv();
      repeat (600) @(negedge clk);
      n_cmp++;
      if (frames.size() !== base + 2) begin
         n_err++;
         $display("FAIL ignore_frames actual=%0d required=%0d", frames.size() - base, 2);
      end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (dut_out(k) !== exp_o[k]) begin
            n_err++;
            $display("FAIL ignore_out%0d actual=%h required=%h", k, dut_out(k), exp_o[k]);
         end
      end
   endtask

   task automatic test_round_robin();
      bit ok; int lat; int base; int slot;
      for (int k = 0; k < 8; k++) adc_val[k] = 16'($urandom);
      for (int p = 0; p < 8; p++) begin
         base = frames.size();
         slot = idx_m;
         do_conv(1'b0, ok, lat);
         model_conv();
         n_cmp++;
         if (!ok) begin
            n_err++;
            $display("FAIL rr_timeout pulse=%0d actual frames=%0d required=2", p, frames.size() - base);
         end else begin
            for (int f = 0; f < 2; f++) begin
               n_cmp++;
               if (frames[base+f] !== cmd_tab[slot] || frame_bits[base+f] !== 16) begin
                  n_err++;
                  $display("FAIL rr_cmd pulse=%0d frame=%0d actual=%h/%0d bits required=%h/16",
                           p, f, frames[base+f], frame_bits[base+f], cmd_tab[slot]);
               end
            end
         end
         for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (dut_out(k) !== exp_o[k]) begin
               n_err++;
               $display("FAIL rr_out pulse=%0d out%0d actual=%h required=%h", p, k, dut_out(k), exp_o[k]);
            end
         end
         repeat (1002 - lat) @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      bit ok; int lat; int base; int falls; int n;
      falls = ss_fall_cnt;
      @(negedge clk) nxt = 1'b1;
      @(negedge clk) nxt = 1'b0;
      n = 0;
      while (ss_fall_cnt < falls + 2 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      repeat (100) @(negedge clk);
      n_cmp++;
      if (SS_n !== 1'b0) begin
         n_err++;
         $display("FAIL abort_in_tx2 actual SS_n=%b required=0", SS_n);
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (SS_n !== 1'b1 || SCLK !== 1'b1) begin
         n_err++;
         $display("FAIL abort_ss actual SS_n=%b SCLK=%b required 1/1", SS_n, SCLK);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (dut_out(k) !== 12'h000) begin
            n_err++;
            $display("FAIL abort_out%0d actual=%h required=000", k, dut_out(k));
         end
      end
      adc_val[0] = 16'($urandom);
      base = frames.size();
      do_conv(1'b0, ok, lat);
      model_conv();
      n_cmp++;
      if (!ok || frames[base] !== 16'h0000 || frames[base+1] !== 16'h0000) begin
         n_err++;
         $display("FAIL abort_next_cmd ok=%0b actual=%h,%h required=0000,0000", ok,
                  ok ? frames[base] : 16'hxxxx, ok ? frames[base+1] : 16'hxxxx);
      end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (dut_out(k) !== exp_o[k]) begin
            n_err++;
            $display("FAIL abort_next_out%0d actual=%h required=%h", k, dut_out(k), exp_o[k]);
         end
      end
   endtask

`ifdef A2D_CNV_CMPLT_EN
   task automatic test_cnv_cmplt();
      bit ok; int lat; int base_p;
      base_p = cmplt_pulses;
      for (int p = 0; p < 4; p++) begin
         adc_val[ch_tab[idx_m]] = 16'($urandom);
         do_conv(1'b0, ok, lat);
         model_conv();
      end
      n_cmp++;
      if (cmplt_pulses - base_p !== 4) begin
         n_err++;
         $display("FAIL cmplt_count actual=%0d required=4", cmplt_pulses - base_p);
      end
      n_cmp++;
      if (cmplt_wide !== 0 || cmplt_miss !== 0) begin
         n_err++;
         $display("FAIL cmplt_shape actual wide=%0d miss=%0d required 0/0", cmplt_wide, cmplt_miss);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_ignore_nxt();
      test_round_robin();
      test_reset_mid();
`ifdef A2D_CNV_CMPLT_EN
      test_cnv_cmplt();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
